// File: rtl/model_offset_controller.sv
// model_offset_controller
// Multi-model position-offset generator for the ray-tracing renderer.
// Each model keeps a working X/Z offset (Y is a constant) that is moved
// either by buttons (selected model only) or by an automatic X ping-pong
// sweep, once per divider tick. A published copy is refreshed only on
// frame_strobe so the renderer never sees a mid-frame change.
module model_offset_controller #(
  parameter int NUM_MODELS  = 2,
  parameter int FIXED_WIDTH = 32,
  parameter int TICK_BITS   = 21,
  parameter logic signed [FIXED_WIDTH-1:0] STEP_Q   = 65536,
  parameter logic signed [FIXED_WIDTH-1:0] MIN_Q    = -4194304,
  parameter logic signed [FIXED_WIDTH-1:0] MAX_Q    = 4194304,
  parameter logic signed [FIXED_WIDTH-1:0] Y_INIT_Q = 720896
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode,
  input  logic [2:0]                          sel,
  input  logic                                up,
  input  logic                                down,
  input  logic                                left,
  input  logic                                right,
  input  logic                                frame_strobe,
  output logic [NUM_MODELS*3*FIXED_WIDTH-1:0] offset,
  output logic                                valid
);

  // One guard bit above the Fixed width so a step never wraps before clamping.
  localparam logic signed [FIXED_WIDTH:0] STEP_W = {STEP_Q[FIXED_WIDTH-1], STEP_Q};
  localparam logic signed [FIXED_WIDTH:0] MIN_W  = {MIN_Q[FIXED_WIDTH-1], MIN_Q};
  localparam logic signed [FIXED_WIDTH:0] MAX_W  = {MAX_Q[FIXED_WIDTH-1], MAX_Q};

  logic [TICK_BITS-1:0] div_reg;
  logic                 tick;
  logic                 valid_reg;

  // Clamp a widened sum back into the legal [MIN_Q, MAX_Q] window.
  function automatic logic signed [FIXED_WIDTH-1:0] saturate(input logic signed [FIXED_WIDTH:0] v);
    if (v >= MAX_W)
      return MAX_Q;
    else if (v <= MIN_W)
      return MIN_Q;
    else
      return v[FIXED_WIDTH-1:0];
  endfunction

  // Tick fires in the cycle the divider is all-ones, just before it wraps.
  always_comb tick = &div_reg;

  // Free-running rate divider; restarts from zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_reg <= '0;
    else
      div_reg <= div_reg + TICK_BITS'(1);
  end

  // valid follows each publish by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      valid_reg <= 1'b0;
    else
      valid_reg <= frame_strobe;
  end

  assign valid = valid_reg;

  generate
    for (genvar gi = 0; gi < NUM_MODELS; gi++) begin : g_model
      logic signed [FIXED_WIDTH-1:0] x_reg, z_reg, x_next, z_next;
      logic signed [FIXED_WIDTH-1:0] pub_x_reg, pub_z_reg;
      logic                          dir_neg_reg, dir_neg_next;
      logic signed [FIXED_WIDTH:0]   x_inc, x_dec, z_inc, z_dec, x_sweep;

      // Widened candidate sums for both directions on both moving axes.
      always_comb begin
        x_inc = {x_reg[FIXED_WIDTH-1], x_reg} + STEP_W;
        x_dec = {x_reg[FIXED_WIDTH-1], x_reg} - STEP_W;
        z_inc = {z_reg[FIXED_WIDTH-1], z_reg} + STEP_W;
        z_dec = {z_reg[FIXED_WIDTH-1], z_reg} - STEP_W;
      end

      // Single-cycle update applied on a tick: sweep or buttons, never both.
      always_comb begin
        x_next       = x_reg;
        z_next       = z_reg;
        dir_neg_next = dir_neg_reg;
        x_sweep      = dir_neg_reg ? x_dec : x_inc;
        if (tick) begin
          if (mode) begin
            if (x_sweep >= MAX_W) begin
              x_next       = MAX_Q;
              dir_neg_next = 1'b1;
            end else if (x_sweep <= MIN_W) begin
              x_next       = MIN_Q;
              dir_neg_next = 1'b0;
            end else begin
              x_next = x_sweep[FIXED_WIDTH-1:0];
            end
          end else if (sel == 3'(gi)) begin
            if (left)
              x_next = saturate(x_inc);
            else if (right)
              x_next = saturate(x_dec);
            if (up)
              z_next = saturate(z_inc);
            else if (down)
              z_next = saturate(z_dec);
          end
        end
      end

      // Working state plus the double-buffered published copy; the publish
      // takes the pre-tick working value when both happen on one edge.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          x_reg       <= '0;
          z_reg       <= '0;
          dir_neg_reg <= 1'b0;
          pub_x_reg   <= '0;
          pub_z_reg   <= '0;
        end else begin
          x_reg       <= x_next;
          z_reg       <= z_next;
          dir_neg_reg <= dir_neg_next;
          if (frame_strobe) begin
            pub_x_reg <= x_reg;
            pub_z_reg <= z_reg;
          end
        end
      end

      assign offset[(gi*3+0)*FIXED_WIDTH +: FIXED_WIDTH] = pub_x_reg;
      assign offset[(gi*3+1)*FIXED_WIDTH +: FIXED_WIDTH] = Y_INIT_Q;
      assign offset[(gi*3+2)*FIXED_WIDTH +: FIXED_WIDTH] = pub_z_reg;
    end
  endgenerate

endmodule

// File: tb/tb_model_offset_controller.sv
// Bench for model_offset_controller: two instances (full range with 2 models,
// narrow range with 3 models) driven by the same inputs, checked every cycle
// against an arithmetic reference model, plus directed table vectors.
module tb_model_offset_controller;

  localparam int     STEP = 65536;
  localparam int     Y0   = 720896;
  localparam int     NMB  = 2;
  localparam int     NMS  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;
  logic [2:0] sel = 3'd0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic frame_strobe = 1'b0;
  logic [NMB*96-1:0] off_b;
  logic [NMS*96-1:0] off_s;
  logic valid_b, valid_s;

  model_offset_controller #(.NUM_MODELS(NMB), .TICK_BITS(4)) dut_big (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .up(up), .down(down),
    .left(left), .right(right), .frame_strobe(frame_strobe),
    .offset(off_b), .valid(valid_b));

  model_offset_controller #(.NUM_MODELS(NMS), .TICK_BITS(4),
                            .MIN_Q(-196608), .MAX_Q(196608)) dut_small (
    .clk(clk), .reset(reset), .mode(mode), .sel(sel), .up(up), .down(down),
    .left(left), .right(right), .frame_strobe(frame_strobe),
    .offset(off_s), .valid(valid_s));

  always #5 clk = ~clk;

  // Reference model state, index 0 = big instance, 1 = small instance.
  longint wx[2][8], wz[2][8], px[2][8], pz[2][8];
  int     dir[2][8];
  bit     pval[2];
  int     cnt;
  bit     last_tick;
  int     nm[2]      = '{NMB, NMS};
  longint maxq[2]    = '{64'd4194304, 64'd196608};
  int     n_checks = 0;
  int     n_fail   = 0;

  typedef struct {
    bit         md;
    logic [2:0] s;
    bit         u, dn, l, r;
    int         ticks;
    int         cm;
    int         ex;
    int         ez;
  } vec_t;
  vec_t tbl[6];

  function automatic longint clampv(input longint v, input int k);
    if (v > maxq[k]) return maxq[k];
    if (v < -maxq[k]) return -maxq[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pval[k] = 1'b0;
      for (int m = 0; m < 8; m++) begin
        wx[k][m] = 0; wz[k][m] = 0; px[k][m] = 0; pz[k][m] = 0; dir[k][m] = 1;
      end
    end
    cnt = 0;
    last_tick = 1'b0;
  endtask

  // One clock edge of behaviour: publish old values, then apply any tick.
  task automatic model_step();
    longint nx;
    last_tick = (cnt == 15);
    cnt = (cnt + 1) % 16;
    for (int k = 0; k < 2; k++) begin
      pval[k] = frame_strobe;
      if (frame_strobe)
        for (int m = 0; m < nm[k]; m++) begin
          px[k][m] = wx[k][m];
          pz[k][m] = wz[k][m];
        end
      if (last_tick)
        for (int m = 0; m < nm[k]; m++) begin
          if (mode) begin
            nx = wx[k][m] + dir[k][m] * STEP;
            if (nx >= maxq[k]) begin wx[k][m] = maxq[k]; dir[k][m] = -1; end
            else if (nx <= -maxq[k]) begin wx[k][m] = -maxq[k]; dir[k][m] = 1; end
            else wx[k][m] = nx;
          end else if (int'(sel) == m) begin
            if (left) wx[k][m] = clampv(wx[k][m] + STEP, k);
            else if (right) wx[k][m] = clampv(wx[k][m] - STEP, k);
            if (up) wz[k][m] = clampv(wz[k][m] + STEP, k);
            else if (down) wz[k][m] = clampv(wz[k][m] - STEP, k);
          end
        end
    end
  endtask

  function automatic logic [287:0] exp_vec(input int k);
    logic [287:0] e;
    e = '0;
    for (int m = 0; m < nm[k]; m++) begin
      e[m*96 +: 32]      = 32'(px[k][m]);
      e[m*96 + 32 +: 32] = 32'(Y0);
      e[m*96 + 64 +: 32] = 32'(pz[k][m]);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [31:0] fb(input int m, input int d);
    return off_b[(m*3+d)*32 +: 32];
  endfunction

  function automatic logic [31:0] fs(input int m, input int d);
    return off_s[(m*3+d)*32 +: 32];
  endfunction

  task automatic check_outputs();
    chk("pub_big", {96'b0, off_b}, exp_vec(0));
    chk("pub_small", off_s, exp_vec(1));
    chk32("valid_big", 32'(valid_b), 32'(pval[0]));
    chk32("valid_small", 32'(valid_s), 32'(pval[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_ticks(input int n);
    int t;
    t = 0;
    while (t < n) begin
      cycle();
      if (last_tick) t++;
    end
  endtask

  task automatic strobe();
    frame_strobe = 1'b1;
    cycle();
    frame_strobe = 1'b0;
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk32("rst_valid", 32'(valid_b), 32'd0);
    chk32("rst_x0", fb(0, 0), 32'd0);
    chk32("rst_y1", fs(1, 1), 32'(Y0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1, 131072, 131072};
    tbl[1] = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 131072, 196608};
    tbl[2] = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 65536, 196608};
    tbl[3] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 0, -131072};
    tbl[4] = '{1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, -131072};
    tbl[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 65536, -131072};

    // Reset state and three strobes with one-cycle valid pulses.
    model_reset();
    @(negedge clk);
    check_outputs();
    chk32("init_y", fb(1, 1), 32'(Y0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe();
      chk32("strobe_valid", 32'(valid_b), 32'd1);
      chk32("strobe_x", fb(0, 0), 32'd0);
      cycle();
      chk32("strobe_valid_drop", 32'(valid_b), 32'd0);
    end

    // Directed manual vectors from the table.
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].md; sel = tbl[i].s;
      up = tbl[i].u; down = tbl[i].dn; left = tbl[i].l; right = tbl[i].r;
      run_ticks(tbl[i].ticks);
      up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
      strobe();
      chk32($sformatf("vec%0d_x", i), fb(tbl[i].cm, 0), 32'(tbl[i].ex));
      chk32($sformatf("vec%0d_z", i), fb(tbl[i].cm, 2), 32'(tbl[i].ez));
      chk32($sformatf("vec%0d_xs", i), fs(tbl[i].cm, 0), 32'(tbl[i].ex));
    end
    chk32("vec_m0_untouched_y", fb(0, 1), 32'(Y0));

    // Saturation at MAX_Q with extra ticks held.
    sel = 3'd0; left = 1'b1;
    run_ticks(70);
    left = 1'b0;
    strobe();
    chk32("sat_big", fb(0, 0), 32'd4194304);
    chk32("sat_small", fs(0, 0), 32'd196608);

    // Auto sweep bouncing off the narrow MAX_Q.
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int seq[5] = '{65536, 131072, 196608, 131072, 65536};
      run_ticks(1);
      strobe();
      for (int m = 0; m < NMS; m++)
        chk32($sformatf("sweep%0d_m%0d", i, m), fs(m, 0), 32'(seq[i]));
      chk32($sformatf("sweep%0d_big", i), fb(1, 0), 32'((i + 1) * STEP));
    end

    // Strobe coinciding with a tick publishes the pre-tick value.
    do_reset();
    mode = 1'b0; sel = 3'd0; left = 1'b1;
    run_ticks(1);
    while (cnt != 15) cycle();
    strobe();
    left = 1'b0;
    chk32("coincide_pre", fb(0, 0), 32'd65536);
    strobe();
    chk32("coincide_post", fb(0, 0), 32'd131072);
    repeat (3) cycle();
    do_reset();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      mode  = ($urandom % 8) < 3;
      sel   = 3'($urandom_range(0, 7) % 5);
      up    = $urandom % 2; down = $urandom % 2;
      left  = $urandom % 2; right = $urandom % 2;
      frame_strobe = ($urandom % 4) == 0;
      cycle();
      if ($urandom % 700 == 0) do_reset();
    end
    frame_strobe = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/model_offset_controller.md
Name: model_offset_controller

Overview:
- Parametrised multi-model position-offset generator for the ray-tracing renderer; supersedes the single-model button controller.
- Holds NUM_MODELS independent Fixed3 offsets. Each offset is driven either manually from buttons (selected model only) or by an automatic X-axis ping-pong sweep.
- Offsets are double-buffered. The published copy changes only on frame_strobe, so the renderer never sees an offset change mid-frame.

Parameters:
- NUM_MODELS, 2, number of model offset channels (1..8).
- FIXED_WIDTH, 32, width of one Fixed component; signed two's complement Q16.16.
- TICK_BITS, 21, width of the free-running rate divider; one tick per 2^TICK_BITS cycles.
- STEP_Q, 65536, per-tick step (1.0 in Q16.16).
- MIN_Q, -4194304, lower clamp for X and Z (-64.0).
- MAX_Q, 4194304, upper clamp for X and Z (+64.0).
- Y_INIT_Q, 720896, constant Y component (11.0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  0 = manual, 1 = auto sweep.
- sel  in  3  model index driven by buttons in manual mode.
- up  in  1  Z += STEP_Q on tick.
- down  in  1  Z -= STEP_Q on tick.
- left  in  1  X += STEP_Q on tick.
- right  in  1  X -= STEP_Q on tick.
- frame_strobe  in  1  one-cycle pulse at frame start; publishes working offsets.
- offset  out  NUM_MODELS*3*FIXED_WIDTH  published offsets. Model m, dim d sits at bits [(m*3+d)*FIXED_WIDTH +: FIXED_WIDTH]; d = 0:X, 1:Y, 2:Z.
- valid  out  1  high for one cycle after each publish.

Behaviour:
- Reset (async, active-high) values:
  - working and published X = 0, Z = 0, Y = Y_INIT_Q for every model;
  - valid = 0; divider = 0; all sweep directions = +.
- Deasserting reset mid-operation restarts the divider from 0. There are no partial updates.
- Divider:
  - TICK_BITS counter increments every cycle.
  - tick = 1 in the cycle when the counter is all-ones. The counter then wraps to 0.
- Manual mode, on tick, working offset of model sel only:
  - up has priority over down; left has priority over right.
  - Buttons are sampled in the tick cycle only.
  - sel >= NUM_MODELS: no change.
- Auto mode, on tick, every model updates X in the same cycle:
  - X_next = X + STEP_Q when dir = +, X - STEP_Q when dir = -.
  - If X_next >= MAX_Q: X = MAX_Q and dir becomes -.
  - If X_next <= MIN_Q: X = MIN_Q and dir becomes +.
  - Z and Y are held; buttons are ignored.
- Arithmetic and clamping:
  - Add/sub is computed FIXED_WIDTH+1 wide, then saturated to [MIN_Q, MAX_Q].
  - No wrap-around is ever visible.
  - Y is never modified.
- Mode changes:
  - A mode change applies from the next tick.
  - Sweep directions are retained across mode switches.
  - Values already out of range cannot occur because of clamping.
- Publish:
  - On the clk edge with frame_strobe = 1, published copy <= working copy, using the value before any same-edge tick update.
  - valid = 1 for the following cycle, else 0.
  - Back-to-back strobes keep valid high continuously.
- Simultaneous tick and frame_strobe:
  - The publish carries the pre-tick values.
  - The tick result appears at the next publish.
- Latency:
  - Button press to working update: at most 2^TICK_BITS cycles.
  - Working to output: one edge after frame_strobe.
- FSM (per update path): IDLE -> (tick) APPLY -> IDLE. APPLY is combinational within the tick cycle, so the update is single-cycle with no stall.

Test Plan:
1. Reset, then 3 frame_strobes -> every model X = 0, Y = 720896, Z = 0; valid pulses 1 cycle after each strobe.
2. TICK_BITS = 4, manual, sel = 1, up and left held 32 cycles, then strobe -> model1 X = Z = 131072; model0 unchanged.
3. TICK_BITS = 4, manual, up and down both held for 1 tick -> Z += 65536; right alone for 1 tick -> X -= 65536.
4. TICK_BITS = 4, MAX_Q = 196608, auto for 5 ticks -> X sequence 65536, 131072, 196608, 131072, 65536 on every model.
5. Manual with left held until X = MAX_Q, then 2 more ticks -> X stays 4194304, no wrap to negative.
6. frame_strobe in the same cycle as a tick (working X = 65536 -> 131072) -> published X = 65536; next strobe publishes 131072. Assert reset mid-frame -> outputs return to reset values immediately.
